// File: rtl/slc3_pkg.sv
// Shared SLC-3 definitions: opcode constants, datapath mux encodings and
// small decode helpers used by the control unit and its memory timer.
package slc3_pkg;

  // IR[15:12] opcode values
  localparam logic [3:0] op_BR   = 4'b0000;
  localparam logic [3:0] op_ADD  = 4'b0001;
  localparam logic [3:0] op_LD   = 4'b0010;
  localparam logic [3:0] op_ST   = 4'b0011;
  localparam logic [3:0] op_JSR  = 4'b0100;
  localparam logic [3:0] op_AND  = 4'b0101;
  localparam logic [3:0] op_LDR  = 4'b0110;
  localparam logic [3:0] op_STR  = 4'b0111;
  localparam logic [3:0] op_RTI  = 4'b1000;
  localparam logic [3:0] op_NOT  = 4'b1001;
  localparam logic [3:0] op_LDI  = 4'b1010;
  localparam logic [3:0] op_STI  = 4'b1011;
  localparam logic [3:0] op_JMP  = 4'b1100;
  localparam logic [3:0] op_PSE  = 4'b1101;
  localparam logic [3:0] op_LEA  = 4'b1110;
  localparam logic [3:0] op_TRAP = 4'b1111;

  // Width of the shared memory wait counter (MEM_WAIT up to 15)
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    PCMUX_INC   = 2'b00,
    PCMUX_BUS   = 2'b01,
    PCMUX_ADDER = 2'b10
  } pcmux_t;

  typedef enum logic [1:0] {
    A2_ZERO  = 2'b00,
    A2_OFF6  = 2'b01,
    A2_OFF9  = 2'b10,
    A2_OFF11 = 2'b11
  } addr2mux_t;

  typedef enum logic [1:0] {
    ALUK_ADD  = 2'b00,
    ALUK_AND  = 2'b01,
    ALUK_NOT  = 2'b10,
    ALUK_PASS = 2'b11
  } aluk_t;

  // Address states are shared by loads and stores; this picks the store path.
  function automatic logic is_store(input logic [3:0] op);
    return (op == op_ST) || (op == op_STR);
  endfunction

endpackage

// File: rtl/slc3_control_unit_mem_timer.sv
// slc3_mem_timer: wait counter and completion logic for the memory states.
// Fixed mode ends an access after MEM_WAIT cycles; handshake mode ends it on
// the first edge with ready_i high (minimum one cycle, no timeout).
module slc3_mem_timer
  import slc3_pkg::*;
#(
  parameter int MEM_WAIT      = 3,
  parameter int MEM_HANDSHAKE = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  input  logic ready_i,
  output logic done_o
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // Access completes on the last counted cycle or on memory ready
  always_comb begin
    done_o = 1'b0;
    if (MEM_HANDSHAKE != 0) done_o = active_i & ready_i;
    else                    done_o = active_i && (cnt_q == WAIT_W'(MEM_WAIT - 1));
  end

  // Counter is zero outside an access, so every access starts from zero
  always_comb begin
    cnt_d = cnt_q;
    if (!active_i || done_o)  cnt_d = '0;
    else if (cnt_q != '1)     cnt_d = cnt_q + 1'b1;
  end

  // Counter register, cleared by reset even mid-access
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/slc3_control_unit.sv
// slc3_control_unit: Moore sequencer/decoder for the SLC-3 datapath.
// Optional feature macro SLC3_PAUSE_EN builds the PSE pause states and LED
// load; without it PSE is treated as an illegal opcode.
module slc3_control_unit
  import slc3_pkg::*;
#(
  parameter int MEM_WAIT      = 3,
  parameter int MEM_HANDSHAKE = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  input  logic       Mem_Ready,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    S_HALT, S_FETCH, S_RD_IR, S_LOAD_IR, S_DECODE, S_BR_CHK, S_BR_TAKE,
    S_ADD, S_AND, S_NOT, S_JMP, S_JSR_LINK, S_JSR_OFF, S_JSRR,
    S_ADDR_R, S_ADDR_PC, S_LEA, S_RD_DATA, S_WB, S_ST_DATA, S_WR_DATA
`ifdef SLC3_PAUSE_EN
    , S_PAUSE1, S_PAUSE2
`endif
  } state_t;

  state_t    state_q, state_d;
  logic      ir5_q;
  logic      mem_active;
  logic      mem_done;
  pcmux_t    pcmux;
  addr2mux_t addr2mux;
  aluk_t     aluk;

  assign mem_active = (state_q == S_RD_IR) || (state_q == S_RD_DATA) ||
                      (state_q == S_WR_DATA);

  slc3_mem_timer #(
    .MEM_WAIT      (MEM_WAIT),
    .MEM_HANDSHAKE (MEM_HANDSHAKE)
  ) u_timer (
    .clk_i    (Clk),
    .rst_i    (Reset),
    .active_i (mem_active),
    .ready_i  (Mem_Ready),
    .done_o   (mem_done)
  );

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_HALT;
    else       state_q <= state_d;
  end

  // IR[5] is captured while decoding so SR2MUX is a registered (Moore) output
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                   ir5_q <= 1'b0;
    else if (state_q == S_DECODE) ir5_q <= IR_5;
  end

`ifdef SLC3_PAUSE_EN
  logic led_q;

  // LED load pulses only on the first cycle of PAUSE1
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) led_q <= 1'b0;
    else       led_q <= (state_d == S_PAUSE1) && (state_q != S_PAUSE1);
  end
`else
  logic unused_continue;
  assign unused_continue = Continue;
`endif

  // SRAM chip/byte enables are permanently active
  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;

  assign PCMUX    = pcmux;
  assign ADDR2MUX = addr2mux;
  assign ALUK     = aluk;

  // Next-state and per-state control decode
  always_comb begin
    state_d    = state_q;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    pcmux      = PCMUX_INC;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    addr2mux   = A2_ZERO;
    aluk       = ALUK_ADD;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
`ifdef SLC3_PAUSE_EN
    LD_LED     = led_q;
`else
    LD_LED     = 1'b0;
`endif

    case (state_q)
      S_HALT: if (Run) state_d = S_FETCH;
      S_FETCH: begin
        LD_MAR = 1'b1; LD_PC = 1'b1; GatePC = 1'b1;
        state_d = S_RD_IR;
      end
      S_RD_IR: begin
        Mem_OE = 1'b0; LD_MDR = 1'b1;
        if (mem_done) state_d = S_LOAD_IR;
      end
      S_LOAD_IR: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        LD_BEN = 1'b1;
        case (Opcode)
          op_BR:              state_d = S_BR_CHK;
          op_ADD:             state_d = S_ADD;
          op_AND:             state_d = S_AND;
          op_NOT:             state_d = S_NOT;
          op_JMP:             state_d = S_JMP;
          op_JSR:             state_d = S_JSR_LINK;
          op_LDR, op_STR:     state_d = S_ADDR_R;
          op_LD, op_ST:       state_d = S_ADDR_PC;
          op_LEA:             state_d = S_LEA;
`ifdef SLC3_PAUSE_EN
          op_PSE:             state_d = S_PAUSE1;
          op_RTI, op_LDI, op_STI, op_TRAP: state_d = S_FETCH;
`else
          op_PSE, op_RTI, op_LDI, op_STI, op_TRAP: state_d = S_FETCH;
`endif
          default:            state_d = S_FETCH;
        endcase
      end
      S_BR_CHK: state_d = BEN ? S_BR_TAKE : S_FETCH;
      S_BR_TAKE: begin
        LD_PC = 1'b1; pcmux = PCMUX_ADDER; addr2mux = A2_OFF9;
        state_d = S_FETCH;
      end
      S_ADD, S_AND: begin
        LD_REG = 1'b1; LD_CC = 1'b1; GateALU = 1'b1;
        SR1MUX = 1'b1; SR2MUX = ir5_q;
        aluk = (state_q == S_AND) ? ALUK_AND : ALUK_ADD;
        state_d = S_FETCH;
      end
      S_NOT: begin
        LD_REG = 1'b1; LD_CC = 1'b1; GateALU = 1'b1;
        SR1MUX = 1'b1; aluk = ALUK_NOT;
        state_d = S_FETCH;
      end
      S_JMP, S_JSRR: begin
        LD_PC = 1'b1; pcmux = PCMUX_ADDER;
        ADDR1MUX = 1'b1; SR1MUX = 1'b1; addr2mux = A2_ZERO;
        state_d = S_FETCH;
      end
      S_JSR_LINK: begin
        LD_REG = 1'b1; DRMUX = 1'b1; GatePC = 1'b1;
        state_d = IR_11 ? S_JSR_OFF : S_JSRR;
      end
      S_JSR_OFF: begin
        LD_PC = 1'b1; pcmux = PCMUX_ADDER; addr2mux = A2_OFF11;
        state_d = S_FETCH;
      end
      S_ADDR_R: begin
        LD_MAR = 1'b1; GateMARMUX = 1'b1;
        ADDR1MUX = 1'b1; SR1MUX = 1'b1; addr2mux = A2_OFF6;
        state_d = is_store(Opcode) ? S_ST_DATA : S_RD_DATA;
      end
      S_ADDR_PC: begin
        LD_MAR = 1'b1; GateMARMUX = 1'b1; addr2mux = A2_OFF9;
        state_d = is_store(Opcode) ? S_ST_DATA : S_RD_DATA;
      end
      S_LEA: begin
        LD_REG = 1'b1; GateMARMUX = 1'b1; addr2mux = A2_OFF9;
        state_d = S_FETCH;
      end
      S_RD_DATA: begin
        Mem_OE = 1'b0; LD_MDR = 1'b1;
        if (mem_done) state_d = S_WB;
      end
      S_WB: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        state_d = S_FETCH;
      end
      S_ST_DATA: begin
        LD_MDR = 1'b1; GateALU = 1'b1; aluk = ALUK_PASS;
        state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        Mem_WE = 1'b0;
        if (mem_done) state_d = S_FETCH;
      end
`ifdef SLC3_PAUSE_EN
      S_PAUSE1: if (Continue)  state_d = S_PAUSE2;
      S_PAUSE2: if (!Continue) state_d = S_FETCH;
`endif
      default: state_d = S_HALT;
    endcase
  end

endmodule

// File: tb/tb_slc3_control_unit.sv
// Scoreboard bench for slc3_control_unit: a fixed-wait instance (MEM_WAIT=3)
// and a handshake instance share the stimulus; expected control words are
// queued per cycle and compared one cycle at a time.
module tb_slc3_control_unit;

  typedef enum int {
    T_HALT, T_FETCH, T_RD_IR, T_LOAD_IR, T_DECODE, T_BR_CHK, T_BR_TAKE,
    T_ADD, T_AND, T_NOT, T_JMP, T_JSR_LINK, T_JSR_OFF, T_JSRR,
    T_ADDR_R, T_ADDR_PC, T_LEA, T_RD_DATA, T_WB, T_ST_DATA, T_WR_DATA,
    T_PAUSE1, T_PAUSE2
  } tst_e;

  typedef struct {
    logic [26:0] exp;
    logic        rdy;
    logic        cont;
    logic        hs;
    int          st;
  } item_t;

  logic       Clk = 1'b0;
  logic       Reset, Run, Continue, IR_5, IR_11, BEN, Mem_Ready;
  logic [3:0] Opcode;

  logic f_ld_mar, f_ld_mdr, f_ld_ir, f_ld_ben, f_ld_cc, f_ld_reg, f_ld_pc, f_ld_led;
  logic f_gpc, f_gmdr, f_galu, f_gmar, f_drm, f_sr1, f_sr2, f_a1;
  logic f_ce, f_ub, f_lb, f_oe, f_we;
  logic [1:0] f_pcm, f_a2, f_alu;
  logic h_ld_mar, h_ld_mdr, h_ld_ir, h_ld_ben, h_ld_cc, h_ld_reg, h_ld_pc, h_ld_led;
  logic h_gpc, h_gmdr, h_galu, h_gmar, h_drm, h_sr1, h_sr2, h_a1;
  logic h_ce, h_ub, h_lb, h_oe, h_we;
  logic [1:0] h_pcm, h_a2, h_alu;

  logic [26:0] sig_f, sig_h;
  assign sig_f = {f_ld_mar, f_ld_mdr, f_ld_ir, f_ld_ben, f_ld_cc, f_ld_reg, f_ld_pc, f_ld_led,
                  f_gpc, f_gmdr, f_galu, f_gmar, f_pcm, f_drm, f_sr1, f_sr2, f_a1, f_a2, f_alu,
                  f_ce, f_ub, f_lb, f_oe, f_we};
  assign sig_h = {h_ld_mar, h_ld_mdr, h_ld_ir, h_ld_ben, h_ld_cc, h_ld_reg, h_ld_pc, h_ld_led,
                  h_gpc, h_gmdr, h_galu, h_gmar, h_pcm, h_drm, h_sr1, h_sr2, h_a1, h_a2, h_alu,
                  h_ce, h_ub, h_lb, h_oe, h_we};

  slc3_control_unit #(.MEM_WAIT(3), .MEM_HANDSHAKE(0)) u_fix (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN), .Mem_Ready(Mem_Ready),
    .LD_MAR(f_ld_mar), .LD_MDR(f_ld_mdr), .LD_IR(f_ld_ir), .LD_BEN(f_ld_ben),
    .LD_CC(f_ld_cc), .LD_REG(f_ld_reg), .LD_PC(f_ld_pc), .LD_LED(f_ld_led),
    .GatePC(f_gpc), .GateMDR(f_gmdr), .GateALU(f_galu), .GateMARMUX(f_gmar),
    .PCMUX(f_pcm), .DRMUX(f_drm), .SR1MUX(f_sr1), .SR2MUX(f_sr2),
    .ADDR1MUX(f_a1), .ADDR2MUX(f_a2), .ALUK(f_alu),
    .Mem_CE(f_ce), .Mem_UB(f_ub), .Mem_LB(f_lb), .Mem_OE(f_oe), .Mem_WE(f_we)
  );

  slc3_control_unit #(.MEM_WAIT(3), .MEM_HANDSHAKE(1)) u_hs (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN), .Mem_Ready(Mem_Ready),
    .LD_MAR(h_ld_mar), .LD_MDR(h_ld_mdr), .LD_IR(h_ld_ir), .LD_BEN(h_ld_ben),
    .LD_CC(h_ld_cc), .LD_REG(h_ld_reg), .LD_PC(h_ld_pc), .LD_LED(h_ld_led),
    .GatePC(h_gpc), .GateMDR(h_gmdr), .GateALU(h_galu), .GateMARMUX(h_gmar),
    .PCMUX(h_pcm), .DRMUX(h_drm), .SR1MUX(h_sr1), .SR2MUX(h_sr2),
    .ADDR1MUX(h_a1), .ADDR2MUX(h_a2), .ALUK(h_alu),
    .Mem_CE(h_ce), .Mem_UB(h_ub), .Mem_LB(h_lb), .Mem_OE(h_oe), .Mem_WE(h_we)
  );

  always #5 Clk = ~Clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  logic  use_hs  = 1'b0;
  item_t sb[$];

  // Expected control word for a state, built from the documented behaviour
  function automatic logic [26:0] sig(input int s, input logic ir5, input logic led);
    logic mar, mdr, ir, ben, cc, reg_, pc, ledb, gpc, gmdr, galu, gmar;
    logic drm, sr1, sr2, a1, oe, we;
    logic [1:0] pcm, a2, alu;
    {mar, mdr, ir, ben, cc, reg_, pc, ledb} = 8'h00;
    {gpc, gmdr, galu, gmar} = 4'h0;
    {drm, sr1, sr2, a1} = 4'h0;
    pcm = 2'b00; a2 = 2'b00; alu = 2'b00; oe = 1'b1; we = 1'b1;
    case (s)
      T_FETCH:             begin mar = 1; pc = 1; gpc = 1; end
      T_RD_IR, T_RD_DATA:  begin oe = 0; mdr = 1; end
      T_LOAD_IR:           begin gmdr = 1; ir = 1; end
      T_DECODE:            ben = 1;
      T_BR_TAKE:           begin pc = 1; pcm = 2'b10; a2 = 2'b10; end
      T_ADD:               begin reg_ = 1; cc = 1; galu = 1; sr1 = 1; sr2 = ir5; alu = 2'b00; end
      T_AND:               begin reg_ = 1; cc = 1; galu = 1; sr1 = 1; sr2 = ir5; alu = 2'b01; end
      T_NOT:               begin reg_ = 1; cc = 1; galu = 1; sr1 = 1; alu = 2'b10; end
      T_JMP, T_JSRR:       begin pc = 1; pcm = 2'b10; a1 = 1; sr1 = 1; a2 = 2'b00; end
      T_JSR_LINK:          begin reg_ = 1; drm = 1; gpc = 1; end
      T_JSR_OFF:           begin pc = 1; pcm = 2'b10; a2 = 2'b11; end
      T_ADDR_R:            begin mar = 1; gmar = 1; a1 = 1; sr1 = 1; a2 = 2'b01; end
      T_ADDR_PC:           begin mar = 1; gmar = 1; a2 = 2'b10; end
      T_LEA:               begin reg_ = 1; gmar = 1; a2 = 2'b10; end
      T_WB:                begin gmdr = 1; reg_ = 1; cc = 1; end
      T_ST_DATA:           begin mdr = 1; galu = 1; alu = 2'b11; end
      T_WR_DATA:           we = 0;
      T_PAUSE1:            ledb = led;
      default:             ;
    endcase
    return {mar, mdr, ir, ben, cc, reg_, pc, ledb, gpc, gmdr, galu, gmar,
            pcm, drm, sr1, sr2, a1, a2, alu, 3'b000, oe, we};
  endfunction

  function automatic void push(input int st, input logic rdy = 1'b0,
                               input logic cont = 1'b0, input logic led = 1'b0);
    item_t it;
    it.exp = sig(st, IR_5, led); it.rdy = rdy; it.cont = cont;
    it.hs = use_hs; it.st = st;
    sb.push_back(it);
  endfunction

  function automatic void push_prefix();
    push(T_FETCH); push(T_RD_IR); push(T_RD_IR); push(T_RD_IR);
    push(T_LOAD_IR); push(T_DECODE);
  endfunction

  // Reset both instances, release into HALT with Run raised
  task automatic start_run();
    @(negedge Clk);
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0; Mem_Ready = 1'b0;
    @(negedge Clk);
    Reset = 1'b0; Run = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Reset = 1'b1; Run = 1'b1;
    @(posedge Clk); #1;
    n_tests++;
    if (sig_f !== sig(T_HALT, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_fix: got %h want %h", sig_f, sig(T_HALT, 1'b0, 1'b0));
    end
    n_tests++;
    if (sig_h !== sig(T_HALT, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_hs: got %h want %h", sig_h, sig(T_HALT, 1'b0, 1'b0));
    end
    @(negedge Clk);
    Reset = 1'b0; Run = 1'b0;
    @(posedge Clk); #1;
    n_tests++;
    if (sig_f !== 27'h0000003) begin
      n_fail++; $display("FAIL halt_idle: got %h want %h", sig_f, 27'h0000003);
    end
  endtask

  task automatic test_alu();
    item_t it; int step;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin Opcode = 4'b0001; IR_5 = 1'b1; end
        1: begin Opcode = 4'b0101; IR_5 = 1'b0; end
        default: begin Opcode = 4'b1001; IR_5 = 1'b1; end
      endcase
      start_run();
      push_prefix();
      push(k == 0 ? T_ADD : (k == 1 ? T_AND : T_NOT));
      push(T_FETCH);
      step = 0;
      while (sb.size() != 0) begin
        it = sb.pop_front();
        Mem_Ready = it.rdy; Continue = it.cont;
        @(posedge Clk); #1;
        n_tests++;
        if ((it.hs ? sig_h : sig_f) !== it.exp) begin
          n_fail++;
          $display("FAIL alu%0d step %0d st %0d: got %h want %h", k, step, it.st,
                   (it.hs ? sig_h : sig_f), it.exp);
        end
        step++;
      end
    end
  endtask

  task automatic test_branch();
    item_t it; int step;
    Opcode = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      BEN = (k == 1);
      start_run();
      push_prefix();
      push(T_BR_CHK);
      if (k == 1) push(T_BR_TAKE);
      push(T_FETCH);
      step = 0;
      while (sb.size() != 0) begin
        it = sb.pop_front();
        Mem_Ready = it.rdy; Continue = it.cont;
        @(posedge Clk); #1;
        n_tests++;
        if ((it.hs ? sig_h : sig_f) !== it.exp) begin
          n_fail++;
          $display("FAIL br_ben%0d step %0d st %0d: got %h want %h", k, step, it.st,
                   (it.hs ? sig_h : sig_f), it.exp);
        end
        step++;
      end
    end
  endtask

  task automatic test_jsr();
    item_t it; int step;
    Opcode = 4'b0100;
    for (int k = 0; k < 2; k++) begin
      IR_11 = (k == 0);
      start_run();
      push_prefix();
      push(T_JSR_LINK);
      push(k == 0 ? T_JSR_OFF : T_JSRR);
      push(T_FETCH);
      step = 0;
      while (sb.size() != 0) begin
        it = sb.pop_front();
        Mem_Ready = it.rdy; Continue = it.cont;
        @(posedge Clk); #1;
        n_tests++;
        if ((it.hs ? sig_h : sig_f) !== it.exp) begin
          n_fail++;
          $display("FAIL jsr%0d step %0d st %0d: got %h want %h", k, step, it.st,
                   (it.hs ? sig_h : sig_f), it.exp);
        end
        step++;
      end
    end
    IR_11 = 1'b0;
  endtask

  // Single-cycle execute paths: JMP, LEA and an unimplemented opcode (RTI)
  task automatic test_misc_ops();
    item_t it; int step;
    for (int k = 0; k < 3; k++) begin
      Opcode = (k == 0) ? 4'b1100 : ((k == 1) ? 4'b1110 : 4'b1000);
      start_run();
      push_prefix();
      if (k == 0) push(T_JMP);
      if (k == 1) push(T_LEA);
      push(T_FETCH);
      step = 0;
      while (sb.size() != 0) begin
        it = sb.pop_front();
        Mem_Ready = it.rdy; Continue = it.cont;
        @(posedge Clk); #1;
        n_tests++;
        if ((it.hs ? sig_h : sig_f) !== it.exp) begin
          n_fail++;
          $display("FAIL misc%0d step %0d st %0d: got %h want %h", k, step, it.st,
                   (it.hs ? sig_h : sig_f), it.exp);
        end
        step++;
      end
    end
  endtask

  task automatic test_load_store();
    item_t it; int step;
    for (int k = 0; k < 3; k++) begin
      Opcode = (k == 0) ? 4'b0110 : ((k == 1) ? 4'b0011 : 4'b0010);
      start_run();
      push_prefix();
      if (k == 0) push(T_ADDR_R); else push(T_ADDR_PC);
      if (k == 1) begin
        push(T_ST_DATA); push(T_WR_DATA); push(T_WR_DATA); push(T_WR_DATA);
      end else begin
        push(T_RD_DATA); push(T_RD_DATA); push(T_RD_DATA); push(T_WB);
      end
      push(T_FETCH);
      step = 0;
      while (sb.size() != 0) begin
        it = sb.pop_front();
        Mem_Ready = it.rdy; Continue = it.cont;
        @(posedge Clk); #1;
        n_tests++;
        if ((it.hs ? sig_h : sig_f) !== it.exp) begin
          n_fail++;
          $display("FAIL ldst%0d step %0d st %0d: got %h want %h", k, step, it.st,
                   (it.hs ? sig_h : sig_f), it.exp);
        end
        step++;
      end
    end
  endtask

  // Handshake instance: rdy in an item is driven during the preceding state
  task automatic test_handshake();
    item_t it; int step;
    use_hs = 1'b1;
    Opcode = 4'b0011;
    start_run();
    push(T_FETCH, 0); push(T_RD_IR, 0); push(T_RD_IR, 0); push(T_LOAD_IR, 1);
    push(T_DECODE, 0); push(T_ADDR_PC, 1); push(T_ST_DATA, 1); push(T_WR_DATA, 1);
    push(T_WR_DATA, 0); push(T_WR_DATA, 0); push(T_WR_DATA, 0); push(T_WR_DATA, 0);
    push(T_FETCH, 1); push(T_RD_IR, 0);
    step = 0;
    while (sb.size() != 0) begin
      it = sb.pop_front();
      Mem_Ready = it.rdy; Continue = it.cont;
      @(posedge Clk); #1;
      n_tests++;
      if ((it.hs ? sig_h : sig_f) !== it.exp) begin
        n_fail++;
        $display("FAIL hs_st step %0d st %0d: got %h want %h", step, it.st,
                 (it.hs ? sig_h : sig_f), it.exp);
      end
      step++;
    end
    Opcode = 4'b0010;
    start_run();
    push(T_FETCH, 0); push(T_RD_IR, 1); push(T_LOAD_IR, 1); push(T_DECODE, 0);
    push(T_ADDR_PC, 0); push(T_RD_DATA, 0); push(T_WB, 1); push(T_FETCH, 0);
    step = 0;
    while (sb.size() != 0) begin
      it = sb.pop_front();
      Mem_Ready = it.rdy; Continue = it.cont;
      @(posedge Clk); #1;
      n_tests++;
      if ((it.hs ? sig_h : sig_f) !== it.exp) begin
        n_fail++;
        $display("FAIL hs_ld step %0d st %0d: got %h want %h", step, it.st,
                 (it.hs ? sig_h : sig_f), it.exp);
      end
      step++;
    end
    Mem_Ready = 1'b0;
    use_hs = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    item_t it; int step;
    Opcode = 4'b0110;
    start_run();
    push_prefix(); push(T_ADDR_R); push(T_RD_DATA); push(T_RD_DATA);
    for (int phase = 0; phase < 2; phase++) begin
      step = 0;
      while (sb.size() != 0) begin
        it = sb.pop_front();
        Mem_Ready = it.rdy; Continue = it.cont;
        @(posedge Clk); #1;
        n_tests++;
        if ((it.hs ? sig_h : sig_f) !== it.exp) begin
          n_fail++;
          $display("FAIL rst_mid%0d step %0d st %0d: got %h want %h", phase, step, it.st,
                   (it.hs ? sig_h : sig_f), it.exp);
        end
        step++;
      end
      if (phase == 0) begin
        Reset = 1'b1;
        #1;
        n_tests++;
        if (f_oe !== 1'b1) begin
          n_fail++; $display("FAIL rst_mid_oe: got %b want 1", f_oe);
        end
        n_tests++;
        if (sig_f !== sig(T_HALT, 1'b0, 1'b0)) begin
          n_fail++; $display("FAIL rst_mid_halt: got %h want %h", sig_f, sig(T_HALT, 1'b0, 1'b0));
        end
        @(negedge Clk);
        Reset = 1'b0;
        push(T_FETCH); push(T_RD_IR); push(T_RD_IR); push(T_RD_IR); push(T_LOAD_IR);
      end
    end
  endtask

  task automatic test_pause();
    item_t it; int step;
    Opcode = 4'b1101;
    start_run();
    push(T_FETCH, 0, 0); push(T_RD_IR, 0, 1); push(T_RD_IR, 0, 1); push(T_RD_IR, 0, 1);
    push(T_LOAD_IR, 0, 1); push(T_DECODE, 0, 1);
`ifdef SLC3_PAUSE_EN
    push(T_PAUSE1, 0, 1, 1); push(T_PAUSE1, 0, 0, 0); push(T_PAUSE2, 0, 1);
    push(T_PAUSE2, 0, 1); push(T_FETCH, 0, 0);
`else
    push(T_FETCH, 0, 1);
`endif
    step = 0;
    while (sb.size() != 0) begin
      it = sb.pop_front();
      Mem_Ready = it.rdy; Continue = it.cont;
      @(posedge Clk); #1;
      n_tests++;
      if ((it.hs ? sig_h : sig_f) !== it.exp) begin
        n_fail++;
        $display("FAIL pause step %0d st %0d: got %h want %h", step, it.st,
                 (it.hs ? sig_h : sig_f), it.exp);
      end
      step++;
    end
    Continue = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0; Opcode = 4'b0000;
    IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0; Mem_Ready = 1'b0;
    test_reset();
    test_alu();
    test_branch();
    test_jsr();
    test_misc_ops();
    test_load_store();
    test_handshake();
    test_reset_mid_access();
    test_pause();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
